// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the cache <-> word-wide memory bridge.
//   mem_req_type    : one line request from the cache (addr, line, rw, valid)
//   mem_data_type   : one line response to the cache (line, ready)
//   cache_data_type : a full 128-bit cache line
//   bridge_state_t  : bridge FSM states
// Helper functions compute the per-word address and select a line word.
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;

    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        cache_data_type    data;
        logic              rw;
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } bridge_state_t;

    // Word k of a line lives at base + 4k. The index is spliced into bits
    // [3:2] so the address can never carry out of the line.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [1:0]        k);
        return {base[ADDR_W-1:4], k, 2'b00};
    endfunction

    function automatic logic [WORD_W-1:0] line_word(input cache_data_type line,
                                                    input logic [1:0]     k);
        return line[{k, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_mem_bridge_if.sv
// ----------------------------------------------------------------------------
// cache_mem_bridge_if
// Bundles the cache-side line port and the RAM-side word port.
//   slave  : the bridge (consumes line requests, drives the word port)
//   master : the environment (cache + RAM)
// Handshake semantics:
//   mem_valid is a request strobe (may be a one-cycle pulse) that the bridge
//   samples only when idle or in its response cycle; mem_ready is a
//   one-cycle completion pulse. On the RAM side ram_req, ram_addr, ram_we
//   and ram_wdata are held stable until a cycle with ram_ack=1, which
//   completes that word; ram_rdata is valid in the same cycle as ram_ack.
//   ram_ack may be high in the first cycle of ram_req (zero-wait RAM).
// ----------------------------------------------------------------------------
interface cache_mem_bridge_if;
    import cache_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    cache_data_type    mem_data_in;
    logic              mem_rw;
    logic              mem_valid;
    cache_data_type    mem_data_out;
    logic              mem_ready;
    logic              busy;

    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_req;
    logic              ram_ack;
    logic [WORD_W-1:0] ram_rdata;

    modport slave (
        input  mem_addr, mem_data_in, mem_rw, mem_valid, ram_ack, ram_rdata,
        output mem_data_out, mem_ready, busy, ram_addr, ram_wdata, ram_we, ram_req
    );

    modport master (
        output mem_addr, mem_data_in, mem_rw, mem_valid, ram_ack, ram_rdata,
        input  mem_data_out, mem_ready, busy, ram_addr, ram_wdata, ram_we, ram_req
    );

endinterface

// File: rtl/cache_mem_bridge_stats.sv
// ----------------------------------------------------------------------------
// cache_mem_bridge_stats
// Completed-transfer counters, present only with CACHE_MEM_BRIDGE_STATS_EN.
//   clk, rst         : clock, asynchronous active-low reset
//   i_fill_done      : one-cycle pulse per completed fill
//   i_wback_done     : one-cycle pulse per completed write-back
//   o_stat_fills     : fill count, wraps modulo 2^32
//   o_stat_wbacks    : write-back count, wraps modulo 2^32
// ----------------------------------------------------------------------------
`ifdef CACHE_MEM_BRIDGE_STATS_EN
module cache_mem_bridge_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fill_done,
    input  logic        i_wback_done,
    output logic [31:0] o_stat_fills,
    output logic [31:0] o_stat_wbacks
);

    logic [31:0] r_fills;
    logic [31:0] r_wbacks;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fills  <= 32'd0;
            r_wbacks <= 32'd0;
        end else begin
            if (i_fill_done)  r_fills  <= r_fills + 32'd1;
            if (i_wback_done) r_wbacks <= r_wbacks + 32'd1;
        end
    end

    assign o_stat_fills  = r_fills;
    assign o_stat_wbacks = r_wbacks;

endmodule
`endif

// File: rtl/cache_mem_bridge.sv
// ----------------------------------------------------------------------------
// cache_mem_bridge
// Serialises 128-bit cache line requests into four 32-bit word transfers
// (ascending address) and reassembles fills into a line with a one-cycle
// mem_ready pulse.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : cache line port + RAM word port (cache_mem_bridge_if)
//   o_dbg_state   : current FSM state
//   stat_fills,
//   stat_wbacks   : transfer counters, only with CACHE_MEM_BRIDGE_STATS_EN
// Optional feature macro: CACHE_MEM_BRIDGE_STATS_EN
// ----------------------------------------------------------------------------
module cache_mem_bridge
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cache_mem_bridge_if.slave   bus,
    output bridge_state_t       o_dbg_state
`ifdef CACHE_MEM_BRIDGE_STATS_EN
    ,
    output logic [31:0]         stat_fills,
    output logic [31:0]         stat_wbacks
`endif
);

    bridge_state_t     r_state;
    logic [ADDR_W-1:0] r_base;
    cache_data_type    r_line;
    logic              r_rw;
    logic [1:0]        r_k;
    logic [95:0]       r_buf;   // words 0..2; word 3 arrives with the last ack
    logic              r_ram_req;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [WORD_W-1:0] r_ram_wdata;
    logic              r_mem_ready;
    logic              r_busy;
    cache_data_type    r_mem_data_out;

    mem_req_type       w_req;
    logic [ADDR_W-1:0] w_base;
    logic              w_accept;
    logic              w_last_ack;

    assign w_req    = '{addr: bus.mem_addr, data: bus.mem_data_in,
                        rw: bus.mem_rw, valid: bus.mem_valid};
    assign w_base   = {w_req.addr[ADDR_W-1:4], 4'b0000};
    // RESP also accepts so a fill issued off mem_ready chains with no idle cycle.
    assign w_accept = w_req.valid && ((r_state == IDLE) || (r_state == RESP));
    assign w_last_ack = (r_state == XFER) && bus.ram_ack && (r_k == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_base         <= '0;
            r_line         <= '0;
            r_rw           <= 1'b0;
            r_k            <= 2'd0;
            r_buf          <= '0;
            r_ram_req      <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_mem_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_mem_data_out <= '0;
        end else begin
            r_mem_ready <= 1'b0;
            if (w_accept) begin
                r_state     <= XFER;
                r_base      <= w_base;
                r_line      <= w_req.data;
                r_rw        <= w_req.rw;
                r_k         <= 2'd0;
                r_ram_req   <= 1'b1;
                r_ram_we    <= w_req.rw;
                r_ram_addr  <= w_base;
                r_ram_wdata <= w_req.data[WORD_W-1:0];
                r_busy      <= 1'b1;
            end else begin
                case (r_state)
                    XFER: begin
                        if (bus.ram_ack) begin
                            if (r_k == 2'd3) begin
                                r_state     <= RESP;
                                r_ram_req   <= 1'b0;
                                r_ram_we    <= 1'b0;
                                r_mem_ready <= 1'b1;
                                if (!r_rw) r_mem_data_out <= {bus.ram_rdata, r_buf};
                            end else begin
                                if (!r_rw) begin
                                    case (r_k)
                                        2'd0:    r_buf[31:0]  <= bus.ram_rdata;
                                        2'd1:    r_buf[63:32] <= bus.ram_rdata;
                                        default: r_buf[95:64] <= bus.ram_rdata;
                                    endcase
                                end
                                r_k         <= r_k + 2'd1;
                                r_ram_addr  <= word_addr(r_base, r_k + 2'd1);
                                r_ram_wdata <= line_word(r_line, r_k + 2'd1);
                            end
                        end
                    end
                    RESP: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ram_req      = r_ram_req;
    assign bus.ram_we       = r_ram_we;
    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_wdata    = r_ram_wdata;
    assign bus.mem_ready    = r_mem_ready;
    assign bus.busy         = r_busy;
    assign bus.mem_data_out = r_mem_data_out;
    assign o_dbg_state      = r_state;

`ifdef CACHE_MEM_BRIDGE_STATS_EN
    // Counted on the final ack so the new totals are visible in RESP.
    cache_mem_bridge_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .i_fill_done   (w_last_ack && !r_rw),
        .i_wback_done  (w_last_ack && r_rw),
        .o_stat_fills  (stat_fills),
        .o_stat_wbacks (stat_wbacks)
    );
`else
    logic w_unused;
    assign w_unused = w_last_ack;
`endif

endmodule

// File: tb/tb_cache_mem_bridge.sv
module tb_cache_mem_bridge;
    import cache_pkg::*;

    logic          clk;
    logic          rst;
    bridge_state_t dbg_state;
`ifdef CACHE_MEM_BRIDGE_STATS_EN
    logic [31:0]   stat_fills;
    logic [31:0]   stat_wbacks;
`endif

    cache_mem_bridge_if bus ();

    cache_mem_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
`ifdef CACHE_MEM_BRIDGE_STATS_EN
        ,
        .stat_fills  (stat_fills),
        .stat_wbacks (stat_wbacks)
`endif
    );

    int n_vec;
    int n_miss;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM responder ----------------
    int          stall_cfg;
    int          stall_cnt;
    logic [31:0] rd_words [4];
    logic [31:0] addr_q  [$];
    logic [31:0] wdata_q [$];
    logic        we_q    [$];
    int          ready_cnt;

    always @(posedge clk) begin
        #1;
        if (bus.mem_ready === 1'b1) ready_cnt++;
        if (bus.ram_req === 1'b1) begin
            if (stall_cnt >= stall_cfg) begin
                bus.ram_ack   = 1'b1;
                bus.ram_rdata = rd_words[bus.ram_addr[3:2]];
                addr_q.push_back(bus.ram_addr);
                wdata_q.push_back(bus.ram_wdata);
                we_q.push_back(bus.ram_we);
                stall_cnt = 0;
            end else begin
                bus.ram_ack = 1'b0;
                stall_cnt++;
            end
        end else begin
            bus.ram_ack = 1'b0;
            stall_cnt   = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        addr_q.delete();
        wdata_q.delete();
        we_q.delete();
        ready_cnt = 0;
    endtask

    task automatic set_rd(input logic [31:0] base_val);
        for (int i = 0; i < 4; i++) rd_words[i] = base_val + 32'(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, returns in the mem_ready cycle (or on timeout).
    task automatic run_xfer(input logic [31:0] addr, input logic [127:0] data,
                            input logic rw, input int stall,
                            output int cycles, output logic ok);
        stall_cfg = stall;
        step();
        clear_logs();
        bus.mem_valid   = 1'b1;
        bus.mem_addr    = addr;
        bus.mem_data_in = data;
        bus.mem_rw      = rw;
        step();
        bus.mem_valid = 1'b0;
        cycles = 1;
        while (bus.mem_ready !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
        ok = (bus.mem_ready === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_vec++;
        if (bus.ram_req !== 1'b0 || bus.ram_we !== 1'b0 || bus.busy !== 1'b0 ||
            bus.mem_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_ctrl: req=%b we=%b busy=%b ready=%b, need all 0",
                     bus.ram_req, bus.ram_we, bus.busy, bus.mem_ready);
        end
        n_vec++;
        if (bus.ram_addr !== 32'd0 || bus.ram_wdata !== 32'd0 || bus.mem_data_out !== 128'd0) begin
            n_miss++;
            $display("FAIL reset_data: addr=%h wdata=%h line=%h, need 0",
                     bus.ram_addr, bus.ram_wdata, bus.mem_data_out);
        end
        n_vec++;
        if (dbg_state !== IDLE) begin
            n_miss++;
            $display("FAIL reset_state: got %0d need %0d", dbg_state, IDLE);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_fill_zero_wait();
        logic [31:0] exp_a;
        stall_cfg = 0;
        set_rd(32'hA0);
        step();
        clear_logs();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_1234;
        bus.mem_rw    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.mem_valid = 1'b0;
            exp_a = 32'h1230 + 32'(4 * i);
            n_vec++;
            if (bus.ram_req !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== exp_a ||
                bus.mem_ready !== 1'b0 || bus.busy !== 1'b1) begin
                n_miss++;
                $display("FAIL fill_word%0d: req=%b we=%b addr=%h ready=%b busy=%b, need 1 0 %h 0 1",
                         i, bus.ram_req, bus.ram_we, bus.ram_addr, bus.mem_ready, bus.busy, exp_a);
            end
        end
        step();
        n_vec++;
        if (bus.mem_ready !== 1'b1 || bus.ram_req !== 1'b0 ||
            bus.mem_data_out !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            n_miss++;
            $display("FAIL fill_resp: ready=%b req=%b line=%h, need 1 0 000000a3000000a2000000a1000000a0",
                     bus.mem_ready, bus.ram_req, bus.mem_data_out);
        end
        step();
        n_vec++;
        if (bus.mem_ready !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== IDLE) begin
            n_miss++;
            $display("FAIL fill_after: ready=%b busy=%b state=%0d, need 0 0 IDLE",
                     bus.mem_ready, bus.busy, dbg_state);
        end
    endtask

    task automatic test_wback_stall();
        int   cyc;
        logic ok;
        logic [127:0] line_v;
        line_v = 128'h44444444_33333333_22222222_11111111;
        run_xfer(32'h0004_0010, line_v, 1'b1, 2, cyc, ok);
        n_vec++;
        if (!ok || cyc != 13) begin
            n_miss++;
            $display("FAIL wb_latency: ready=%b cycles=%0d, need 1 at 13", ok, cyc);
        end
        n_vec++;
        if (addr_q.size() != 4) begin
            n_miss++;
            $display("FAIL wb_count: got %0d words need 4", addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (addr_q[i] !== 32'h0004_0010 + 32'(4 * i) || we_q[i] !== 1'b1 ||
                    wdata_q[i] !== 32'h11111111 * 32'(i + 1)) begin
                    n_miss++;
                    $display("FAIL wb_word%0d: addr=%h we=%b data=%h, need %h 1 %h", i,
                             addr_q[i], we_q[i], wdata_q[i], 32'h0004_0010 + 32'(4 * i),
                             32'h11111111 * 32'(i + 1));
                end
            end
        end
        n_vec++;
        if (bus.mem_data_out !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            n_miss++;
            $display("FAIL wb_keep_line: got %h need previous fill line", bus.mem_data_out);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic ok;
        set_rd(32'hB0);
        run_xfer(32'h0000_3000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b1, 0, cyc, ok);
        n_vec++;
        if (!ok || cyc != 5) begin
            n_miss++;
            $display("FAIL b2b_wb_latency: ready=%b cycles=%0d, need 1 at 5", ok, cyc);
        end
        // In the RESP cycle: chain a fill.
        clear_logs();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_2000;
        bus.mem_rw    = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_busy_resp: got %b need 1", bus.busy);
        end
        step();
        bus.mem_valid = 1'b0;
        n_vec++;
        if (dbg_state !== XFER || bus.ram_req !== 1'b1 || bus.ram_addr !== 32'h2000 ||
            bus.ram_we !== 1'b0 || bus.busy !== 1'b1 || bus.mem_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_chain: state=%0d req=%b addr=%h we=%b busy=%b ready=%b, need XFER 1 2000 0 1 0",
                     dbg_state, bus.ram_req, bus.ram_addr, bus.ram_we, bus.busy, bus.mem_ready);
        end
        cyc = 1;
        while (bus.mem_ready !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        n_vec++;
        if (bus.mem_ready !== 1'b1 || cyc != 5 ||
            bus.mem_data_out !== 128'h000000B3_000000B2_000000B1_000000B0) begin
            n_miss++;
            $display("FAIL b2b_fill: ready=%b cycles=%0d line=%h, need 1 5 000000b3000000b2000000b1000000b0",
                     bus.mem_ready, cyc, bus.mem_data_out);
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        logic ok;
        stall_cfg = 0;
        set_rd(32'hC0);
        step();
        clear_logs();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_5000;
        bus.mem_rw    = 1'b0;
        step();
        bus.mem_valid = 1'b0;
        step();
        step();   // words 0 and 1 have been acked, word 2 is in flight
        #3;
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.ram_req !== 1'b0 || bus.busy !== 1'b0 || bus.mem_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_mid_async: req=%b busy=%b ready=%b, need 0 0 0",
                     bus.ram_req, bus.busy, bus.mem_ready);
        end
        step();
        rst = 1'b1;
        ready_cnt = 0;
        for (int i = 0; i < 8; i++) step();
        n_vec++;
        if (ready_cnt != 0 || bus.mem_data_out !== 128'd0) begin
            n_miss++;
            $display("FAIL rst_mid_quiet: ready pulses=%0d line=%h, need 0 and 0",
                     ready_cnt, bus.mem_data_out);
        end
        set_rd(32'hD0);
        run_xfer(32'h0000_6008, 128'd0, 1'b0, 0, cyc, ok);
        n_vec++;
        if (!ok || bus.mem_data_out !== 128'h000000D3_000000D2_000000D1_000000D0) begin
            n_miss++;
            $display("FAIL rst_mid_refill: ready=%b line=%h, need 1 000000d3000000d2000000d1000000d0",
                     ok, bus.mem_data_out);
        end
    endtask

    task automatic test_ignored_req();
        set_rd(32'hE0);
        stall_cfg = 1;
        step();
        clear_logs();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_7000;
        bus.mem_rw    = 1'b0;
        step();
        bus.mem_valid = 1'b0;
        step();
        bus.mem_valid   = 1'b1;   // stray request during XFER
        bus.mem_addr    = 32'h0000_9990;
        bus.mem_rw      = 1'b1;
        bus.mem_data_in = 128'hFFFF;
        step();
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_vec++;
        if (ready_cnt != 1 || addr_q.size() != 4) begin
            n_miss++;
            $display("FAIL ign_count: ready pulses=%0d words=%0d, need 1 and 4",
                     ready_cnt, addr_q.size());
        end else begin
            n_vec++;
            if (addr_q[0] !== 32'h7000 || addr_q[3] !== 32'h700C || we_q[1] !== 1'b0 || we_q[3] !== 1'b0) begin
                n_miss++;
                $display("FAIL ign_addr: a0=%h a3=%h we1=%b we3=%b, need 7000 700c 0 0",
                         addr_q[0], addr_q[3], we_q[1], we_q[3]);
            end
        end
        n_vec++;
        if (bus.mem_data_out !== 128'h000000E3_000000E2_000000E1_000000E0 || bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL ign_line: line=%h busy=%b, need 000000e3000000e2000000e1000000e0 0",
                     bus.mem_data_out, bus.busy);
        end
    endtask

`ifdef CACHE_MEM_BRIDGE_STATS_EN
    task automatic test_stats();
        int   cyc;
        logic ok;
        rst = 1'b0;
        step();
        n_vec++;
        if (stat_fills !== 32'd0 || stat_wbacks !== 32'd0) begin
            n_miss++;
            $display("FAIL stats_reset: fills=%0d wbacks=%0d, need 0 0", stat_fills, stat_wbacks);
        end
        rst = 1'b1;
        set_rd(32'h10);
        run_xfer(32'h100, 128'd0, 1'b0, 0, cyc, ok);
        run_xfer(32'h200, 128'd1, 1'b1, 0, cyc, ok);
        run_xfer(32'h300, 128'd0, 1'b0, 1, cyc, ok);
        run_xfer(32'h400, 128'd2, 1'b1, 0, cyc, ok);
        run_xfer(32'h500, 128'd0, 1'b0, 0, cyc, ok);
        step();
        n_vec++;
        if (stat_fills !== 32'd3 || stat_wbacks !== 32'd2) begin
            n_miss++;
            $display("FAIL stats_count: fills=%0d wbacks=%0d, need 3 2", stat_fills, stat_wbacks);
        end
    endtask
`endif

    initial begin
        n_vec           = 0;
        n_miss          = 0;
        stall_cfg       = 0;
        stall_cnt       = 0;
        ready_cnt       = 0;
        rst             = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_data_in = '0;
        bus.mem_rw      = 1'b0;
        bus.mem_valid   = 1'b0;
        bus.ram_ack     = 1'b0;
        bus.ram_rdata   = '0;
        for (int i = 0; i < 4; i++) rd_words[i] = '0;

        test_reset();
        test_fill_zero_wait();
        test_wback_stall();
        test_back_to_back();
        test_reset_mid();
        test_ignored_req();
`ifdef CACHE_MEM_BRIDGE_STATS_EN
        test_stats();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
